// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and the write-back entry type used by the
// write-back arbiter and the 4x16 register file.
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 4;
  localparam int DEPTH    = 2;

  // One queued register-file write: destination, value, and whether it is
  // still allowed to reach the register file.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              live;
  } wb_entry_t;

  // One-hot decode of a register address over the full address space.
  function automatic logic [2**ADDR_W-1:0] addrOneHot(input logic [ADDR_W-1:0] a);
    logic [2**ADDR_W-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: circular buffer of load results waiting for the register-file write
// port. Each slot carries a live bit that a younger ALU write to the same
// register can clear, so the stale load is dropped when it reaches the head.
// Optional macro REGFILE_WB_SCOREBOARD_EN adds the liveMask output.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  wb_entry_t         pushEntry,
  input  logic              pop,
  input  logic              killValid,
  input  logic [ADDR_W-1:0] killAddr,
  output wb_entry_t         headEntry,
  output logic              empty,
`ifdef REGFILE_WB_SCOREBOARD_EN
  output logic [2**ADDR_W-1:0] liveMask,
`endif
  output logic              full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [DEPTH-1:0]  liveBits;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W:0]    count;

  // Pointers, occupancy and live bits; kill first, then pop, then push so
  // that a load pushed alongside a matching ALU write stays live.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      liveBits <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (killValid && (addrMem[i] == killAddr)) begin
          liveBits[i] <= 1'b0;
        end
      end
      if (pop) begin
        liveBits[rdPtr] <= 1'b0;
        rdPtr           <= rdPtr + 1'b1;
      end
      if (push) begin
        liveBits[wrPtr] <= pushEntry.live;
        wrPtr           <= wrPtr + 1'b1;
      end
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  // Payload storage needs no reset; the live bits guard every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtr] <= pushEntry.addr;
      dataMem[wrPtr] <= pushEntry.data;
    end
  end

  // Head view and occupancy flags, all derived from registered state.
  always_comb begin
    headEntry.addr = addrMem[rdPtr];
    headEntry.data = dataMem[rdPtr];
    headEntry.live = liveBits[rdPtr];
    empty          = (count == '0);
    full           = (count == (PTR_W+1)'(DEPTH));
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  // Registers that still have a live load queued for them.
  always_comb begin
    liveMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (liveBits[i]) begin
        liveMask = liveMask | addrOneHot(addrMem[i]);
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the register-file write port. ALU results win every
// cycle; load results queue in wb_fifo and drain when the ALU is idle.
// Optional macro REGFILE_WB_SCOREBOARD_EN exports the pending-write scoreboard;
// without it pending is tied to zero.
// DATA_W / ADDR_W must match the values in regfile_pkg, which sizes wb_entry_t.
module regfile_wb_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DEPTH  = regfile_pkg::DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 rf_write,
  output logic [ADDR_W-1:0]    rf_wr_addr,
  output logic [DATA_W-1:0]    rf_wr_data,
  output logic [2**ADDR_W-1:0] pending
);

  regfile_pkg::wb_entry_t headEntry;
  regfile_pkg::wb_entry_t pushEntry;
  logic              fifoEmpty;
  logic              fifoFull;
  logic              accept;
  logic              push;
  logic              pop;
  logic              selWrite;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;
`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [2**ADDR_W-1:0] liveMask;
`endif

  // Ready depends only on the registered occupancy, never on mem_valid.
  assign mem_ready = !fifoFull;
  assign accept    = mem_valid && !fifoFull;

  // Loads entering the queue always start out live.
  always_comb begin
    pushEntry.addr = mem_addr;
    pushEntry.data = mem_data;
    pushEntry.live = 1'b1;
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushEntry(pushEntry),
    .pop      (pop),
    .killValid(alu_valid),
    .killAddr (alu_addr),
    .headEntry(headEntry),
    .empty    (fifoEmpty),
`ifdef REGFILE_WB_SCOREBOARD_EN
    .liveMask (liveMask),
`endif
    .full     (fifoFull)
  );

  // Priority select: ALU, then queued head (dropped if dead), then a load
  // bypassing an empty queue, otherwise no write.
  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    selWrite = 1'b0;
    selAddr  = alu_addr;
    selData  = alu_data;
    if (alu_valid) begin
      selWrite = 1'b1;
      push     = accept;
    end else if (!fifoEmpty) begin
      pop      = 1'b1;
      selWrite = headEntry.live;
      selAddr  = headEntry.addr;
      selData  = headEntry.data;
      push     = accept;
    end else if (accept) begin
      selWrite = 1'b1;
      selAddr  = mem_addr;
      selData  = mem_data;
    end
  end

  // Output register; address and data hold while no write is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      rf_write <= selWrite;
      if (selWrite) begin
        rf_wr_addr <= selAddr;
        rf_wr_data <= selData;
      end
    end
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  // Outstanding writes: live queued loads plus the write leaving this cycle.
  always_comb begin
    pending = liveMask;
    if (rf_write) begin
      pending[rf_wr_addr] = 1'b1;
    end
  end
`else
  assign pending = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random stimulus checked against a
// queue-based model of the write-back arbitration rules.
// Honours REGFILE_WB_SCOREBOARD_EN for the expected pending value.
module tb_regfile_wb_arbiter;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DP = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          live;
  } entT;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          rf_write;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic [7:0]    pending;

  int            total = 0;
  int            bad   = 0;
  entT           mq[$];
  logic          expW;
  logic [AW-1:0] expA;
  logic [DW-1:0] expD;
  bit            lastAccepted;
  int            loadIdx;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .rf_write  (rf_write),
    .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data),
    .pending   (pending)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expPending();
    logic [7:0] p;
    p = '0;
    foreach (mq[i]) if (mq[i].live) p[mq[i].addr] = 1'b1;
    if (expW) p[expA] = 1'b1;
`ifndef REGFILE_WB_SCOREBOARD_EN
    p = '0;
`endif
    return p;
  endfunction

  task automatic checkOutput();
    checkVal("rf_write", 32'(rf_write), 32'(expW));
    if (expW) begin
      checkVal("rf_wr_addr", 32'(rf_wr_addr), 32'(expA));
      checkVal("rf_wr_data", 32'(rf_wr_data), 32'(expD));
    end
    checkVal("pending", 32'(pending), 32'(expPending()));
  endtask

  // Drive one cycle of inputs, advance the model by the arbitration rules,
  // then check the registered outputs just after the clock edge.
  task automatic applyStimulus(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                               input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    bit  ready;
    bit  acc;
    entT h;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    ready = (mq.size() < DP);
    checkVal("mem_ready", 32'(mem_ready), 32'(ready));
    acc = mv && ready;
    lastAccepted = acc;
    if (av) begin
      foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 1'b0;
      expW = 1'b1; expA = aa; expD = ad;
      if (acc) mq.push_back('{addr: ma, data: md, live: 1'b1});
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      expW = h.live;
      if (h.live) begin expA = h.addr; expD = h.data; end
      if (acc) mq.push_back('{addr: ma, data: md, live: 1'b1});
    end else if (acc) begin
      expW = 1'b1; expA = ma; expD = md;
    end else begin
      expW = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Reset with busy inputs to show reset wins over everything.
  task automatic doReset();
    rst = 1'b1;
    alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'hDEAD;
    mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 16'hCAFE;
    @(posedge clk);
    #1;
    rst = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0;
    mq.delete();
    expW = 1'b0; expA = '0; expD = '0;
    checkVal("rst_rf_write", 32'(rf_write), 32'd0);
    checkVal("rst_rf_wr_addr", 32'(rf_wr_addr), 32'd0);
    checkVal("rst_rf_wr_data", 32'(rf_wr_data), 32'd0);
    checkVal("rst_pending", 32'(pending), 32'd0);
    checkVal("rst_mem_ready", 32'(mem_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    expW = 1'b0; expA = '0; expD = '0;
    @(posedge clk);
    doReset();

    // ALU-only write to register 2.
    applyStimulus(1'b1, 3'd2, 16'h1234, 1'b0, '0, '0);
    checkVal("alu_only_data", 32'(rf_wr_data), 32'h1234);
    idle();

    // Load straight through the empty queue.
    applyStimulus(1'b0, '0, '0, 1'b1, 3'd1, 16'hBEEF);
    checkVal("load_bypass_data", 32'(rf_wr_data), 32'hBEEF);
    idle();

    // Back-pressure: ALU busy four cycles while three loads are offered.
    loadIdx = 0;
    for (int c = 0; c < 9; c++) begin
      applyStimulus(c < 4, 3'd5, 16'(16'h5000 + c), loadIdx < 3, 3'(loadIdx),
                    16'(16'hA000 + loadIdx));
      if (lastAccepted) loadIdx++;
      if (c == 3) checkVal("bp_accepted_during_alu", 32'(loadIdx), 32'd2);
    end
    checkVal("bp_all_accepted", 32'(loadIdx), 32'd3);
    idle(); idle();

    // Kill: queued load to r3 is overtaken by an ALU write to r3.
    applyStimulus(1'b1, 3'd6, 16'h0600, 1'b1, 3'd3, 16'hAAAA);
    applyStimulus(1'b1, 3'd3, 16'h5555, 1'b0, '0, '0);
    checkVal("kill_alu_data", 32'(rf_wr_data), 32'h5555);
    idle();
    checkVal("kill_dead_pop", 32'(rf_write), 32'd0);
    idle();

    // Same-cycle ALU and load to register 0.
    applyStimulus(1'b1, 3'd0, 16'h0001, 1'b1, 3'd0, 16'h0002);
    idle();
    checkVal("same_cycle_load_data", 32'(rf_wr_data), 32'h0002);
    idle();

    // Reset while the queue holds two entries.
    applyStimulus(1'b1, 3'd5, 16'h1111, 1'b1, 3'd4, 16'h2222);
    applyStimulus(1'b1, 3'd5, 16'h3333, 1'b1, 3'd6, 16'h4444);
    doReset();
    idle(); idle();

    // Random traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 99) < 55, 3'($urandom_range(0, 4)), 16'($urandom),
                      $urandom_range(0, 99) < 60, 3'($urandom_range(0, 7)), 16'($urandom));
      end
    end
    for (int c = 0; c < 4; c++) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
